// File: rtl/reg_fetch_pkg.sv
// Shared types and constants for the register fetch sequencer.
// FunSel codes, fetch modes, FSM states and the low-byte FunSel helper.
package reg_fetch_pkg;

  localparam logic [2:0] FS_DEC     = 3'b000;
  localparam logic [2:0] FS_INC     = 3'b001;
  localparam logic [2:0] FS_LOAD    = 3'b010;
  localparam logic [2:0] FS_CLR     = 3'b011;
  localparam logic [2:0] FS_WLO_CLR = 3'b100;
  localparam logic [2:0] FS_WLO     = 3'b101;
  localparam logic [2:0] FS_WHI     = 3'b110;
  localparam logic [2:0] FS_SEXT    = 3'b111;

  localparam int WAIT_TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    MODE_WORD   = 2'b00,
    MODE_BYTE_Z = 2'b01,
    MODE_BYTE_S = 2'b10,
    MODE_BYTE_L = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_LO = 3'd1,
    ST_WR_LO  = 3'd2,
    ST_REQ_HI = 3'd3,
    ST_WR_HI  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  function automatic logic [2:0] lo_funsel(input mode_e m);
    logic [2:0] fs;
    fs = FS_WLO;
    unique case (m)
      MODE_WORD:   fs = FS_WLO;
      MODE_BYTE_Z: fs = FS_WLO_CLR;
      MODE_BYTE_S: fs = FS_SEXT;
      MODE_BYTE_L: fs = FS_WLO;
    endcase
    return fs;
  endfunction

endpackage

// File: rtl/reg_fetch_sequencer_timer.sv
// Memory wait counter with limit compare for the fetch sequencer.
// Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  // Count request cycles that end without an ack.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Limit reached on this edge and no ack arrived with it.
  assign o_expire = i_inc && (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/reg_fetch_sequencer.sv
// Fetches one or two bytes over a req/ack port and issues FunSel/E writes.
// Optional wait timeout abort is built when FETCH_TIMEOUT_EN is defined.
module reg_fetch_sequencer
  import reg_fetch_pkg::*;
#(
  parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEF
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Start,
  input  logic [1:0]  i_Mode,
  output logic        o_Mem_Req,
  input  logic        i_Mem_Ack,
  input  logic [7:0]  i_Mem_Data,
  output logic        o_Dst_E,
  output logic [2:0]  o_Dst_FunSel,
  output logic [15:0] o_Dst_I,
  output logic        o_PC_E,
  output logic [2:0]  o_PC_FunSel,
  output logic        o_Busy,
  output logic        o_Done,
  output logic        o_Error
);

  state_e      r_state;
  mode_e       r_mode;
  logic        r_mem_req;
  logic        r_dst_e;
  logic [2:0]  r_dst_fs;
  logic [15:0] r_dst_i;
  logic        r_pc_e;
  logic [2:0]  r_pc_fs;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

`ifdef FETCH_TIMEOUT_EN
  logic w_clr;
  logic w_inc;
  logic w_expire;

  assign w_clr = ((r_state == ST_IDLE) && i_Start) ||
                 ((r_state == ST_WR_LO) && (r_mode == MODE_WORD));
  assign w_inc = ((r_state == ST_REQ_LO) || (r_state == ST_REQ_HI)) &&
                 !i_Mem_Ack;

  fetch_wait_timer #(
    .LIMIT(WAIT_TIMEOUT)
  ) u_timer (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_clr   (w_clr),
    .i_inc   (w_inc),
    .o_expire(w_expire)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (WAIT_TIMEOUT > 0);
`endif

  // Fetch FSM; outputs are registered for the state being entered.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state   <= ST_IDLE;
      r_mode    <= MODE_WORD;
      r_mem_req <= 1'b0;
      r_dst_e   <= 1'b0;
      r_dst_fs  <= FS_DEC;
      r_dst_i   <= 16'h0000;
      r_pc_e    <= 1'b0;
      r_pc_fs   <= FS_DEC;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_dst_e  <= 1'b0;
      r_dst_fs <= FS_DEC;
      r_pc_e   <= 1'b0;
      r_pc_fs  <= FS_DEC;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (i_Start) begin
            r_mode    <= mode_e'(i_Mode);
            r_state   <= ST_REQ_LO;
            r_mem_req <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        ST_REQ_LO, ST_REQ_HI: begin
          if (i_Mem_Ack) begin
            r_mem_req <= 1'b0;
            r_dst_e   <= 1'b1;
            r_pc_e    <= 1'b1;
            r_pc_fs   <= FS_INC;
            r_dst_i   <= {i_Mem_Data, i_Mem_Data};
            if (r_state == ST_REQ_LO) begin
              r_state  <= ST_WR_LO;
              r_dst_fs <= lo_funsel(r_mode);
            end else begin
              r_state  <= ST_WR_HI;
              r_dst_fs <= FS_WHI;
            end
          end
`ifdef FETCH_TIMEOUT_EN
          else if (w_expire) begin
            r_state   <= ST_ERR;
            r_mem_req <= 1'b0;
            r_err     <= 1'b1;
          end
`endif
        end
        ST_WR_LO: begin
          if (r_mode == MODE_WORD) begin
            r_state   <= ST_REQ_HI;
            r_mem_req <= 1'b1;
          end else begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_WR_HI: begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end
        ST_DONE, ST_ERR: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign o_Mem_Req    = r_mem_req;
  assign o_Dst_E      = r_dst_e;
  assign o_Dst_FunSel = r_dst_fs;
  assign o_Dst_I      = r_dst_i;
  assign o_PC_E       = r_pc_e;
  assign o_PC_FunSel  = r_pc_fs;
  assign o_Busy       = r_busy;
  assign o_Done       = r_done;
  assign o_Error      = r_err;

endmodule

// File: tb/tb_reg_fetch_sequencer.sv
// Self-checking bench for reg_fetch_sequencer.
// Vector table plus scoreboard of expected destination writes.
module tb_reg_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        i_Start;
  logic [1:0]  i_Mode;
  logic        o_Mem_Req;
  logic        i_Mem_Ack;
  logic [7:0]  i_Mem_Data;
  logic        o_Dst_E;
  logic [2:0]  o_Dst_FunSel;
  logic [15:0] o_Dst_I;
  logic        o_PC_E;
  logic [2:0]  o_PC_FunSel;
  logic        o_Busy;
  logic        o_Done;
  logic        o_Error;

  reg_fetch_sequencer #(
    .WAIT_TIMEOUT(15)
  ) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Start     (i_Start),
    .i_Mode      (i_Mode),
    .o_Mem_Req   (o_Mem_Req),
    .i_Mem_Ack   (i_Mem_Ack),
    .i_Mem_Data  (i_Mem_Data),
    .o_Dst_E     (o_Dst_E),
    .o_Dst_FunSel(o_Dst_FunSel),
    .o_Dst_I     (o_Dst_I),
    .o_PC_E      (o_PC_E),
    .o_PC_FunSel (o_PC_FunSel),
    .o_Busy      (o_Busy),
    .o_Done      (o_Done),
    .o_Error     (o_Error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fs;
    logic [15:0] di;
  } wr_t;

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  d0;
    logic [7:0]  d1;
    int          wt;
    bit          tie;
    bit          poke;
    logic [15:0] pre;
    logic [15:0] expv;
    logic [2:0]  fs;
    int          done_c;
    int          reqs;
  } vec_t;

  wr_t         exp_q[$];
  logic [15:0] model_reg;
  int          n_checks = 0;
  int          n_errs = 0;
  int          n_pc = 0;
  int          n_done = 0;
  int          n_errp = 0;

  function automatic void check(input string name,
                                input logic [31:0] act,
                                input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endfunction

  // Destination register model driven by the FunSel encoding.
  function automatic logic [15:0] apply(input logic [15:0] r,
                                        input logic [2:0] fs,
                                        input logic [15:0] d);
    case (fs)
      3'b100:  return {8'h00, d[7:0]};
      3'b101:  return {r[15:8], d[7:0]};
      3'b110:  return {d[15:8], r[7:0]};
      3'b111:  return {{8{d[7]}}, d[7:0]};
      default: return r;
    endcase
  endfunction

  // Write monitor: pairs enables and pops the scoreboard.
  always @(negedge clk) begin
    if (o_Done) n_done++;
    if (o_Error) n_errp++;
    if (o_Dst_E || o_PC_E) begin
      n_pc++;
      check("wr_pair", {27'd0, o_Dst_E, o_PC_E, o_PC_FunSel},
            {27'd0, 5'b11001});
      if (o_Dst_E) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {13'd0, o_Dst_FunSel, o_Dst_I}, 32'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("dst_funsel", {29'd0, o_Dst_FunSel}, {29'd0, e.fs});
          check("dst_i", {16'd0, o_Dst_I}, {16'd0, e.di});
        end
        model_reg = apply(model_reg, o_Dst_FunSel, o_Dst_I);
      end
    end
  end

  task automatic do_fetch(input vec_t v, input string tag);
    int rc, bi, cyc, reqs, pc0, dn0, er0, nb;
    bit got;
    model_reg = v.pre;
    nb = (v.mode == 2'b00) ? 2 : 1;
    exp_q.push_back('{v.fs, {v.d0, v.d0}});
    if (nb == 2) exp_q.push_back('{3'b110, {v.d1, v.d1}});
    pc0 = n_pc; dn0 = n_done; er0 = n_errp;
    rc = 0; bi = 0; reqs = 0; cyc = 0; got = 0;
    i_Mode = v.mode;
    i_Start = 1'b1;
    i_Mem_Ack = v.tie;
    i_Mem_Data = v.d0;
    for (int c = 1; c <= 80 && !got; c++) begin
      @(negedge clk);
      i_Start = v.poke && (c == 2);
      if (v.poke && c == 2) i_Mode = 2'b01;
      if (o_Dst_E) begin
        bi++;
        rc = 0;
      end
      i_Mem_Data = (bi == 0) ? v.d0 : v.d1;
      if (o_Mem_Req) begin
        rc++;
        reqs++;
      end
      i_Mem_Ack = v.tie || (o_Mem_Req && rc > v.wt);
      if (o_Done) begin
        got = 1;
        cyc = c;
      end
    end
    i_Mem_Ack = 1'b0;
    i_Start = 1'b0;
    check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    check({tag, "_done_cycle"}, cyc, v.done_c);
    check({tag, "_req_cycles"}, reqs, v.reqs);
    check({tag, "_pc_pulses"}, n_pc - pc0, nb);
    check({tag, "_no_error"}, n_errp - er0, 0);
    check({tag, "_reg"}, {16'd0, model_reg}, {16'd0, v.expv});
    check({tag, "_q_empty"}, exp_q.size(), 0);
    @(negedge clk);
    check({tag, "_idle_after"}, {30'd0, o_Busy, o_Done}, 32'd0);
    check({tag, "_one_done"}, n_done - dn0, 1);
  endtask

  vec_t tbl[7];

  initial begin
    int pc0, dn0, reqs, act;
    bit got;
    tbl[0] = '{2'b00, 8'h34, 8'h12, 0,  1, 0, 16'h0000, 16'h1234,
               3'b101, 5, 2};
    tbl[1] = '{2'b10, 8'h9C, 8'h00, 3,  0, 0, 16'h0000, 16'hFF9C,
               3'b111, 6, 4};
    tbl[2] = '{2'b01, 8'h9C, 8'h00, 0,  0, 0, 16'hFFFF, 16'h009C,
               3'b100, 3, 1};
    tbl[3] = '{2'b11, 8'h9C, 8'h00, 1,  0, 0, 16'hABCD, 16'hAB9C,
               3'b101, 4, 2};
    tbl[4] = '{2'b00, 8'h5A, 8'hA5, 2,  0, 0, 16'h0000, 16'hA55A,
               3'b101, 9, 6};
    tbl[5] = '{2'b01, 8'h3C, 8'h00, 14, 0, 0, 16'hFFFF, 16'h003C,
               3'b100, 17, 15};
    tbl[6] = '{2'b00, 8'h11, 8'h22, 1,  0, 1, 16'h0000, 16'h2211,
               3'b101, 7, 4};

    model_reg = 16'h0000;
    rst = 1'b1;
    i_Start = 1'b0;
    i_Mode = 2'b00;
    i_Mem_Ack = 1'b0;
    i_Mem_Data = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {5'd0, o_Mem_Req, o_Dst_E, o_Dst_FunSel, o_Dst_I, o_PC_E,
           o_PC_FunSel, o_Busy, o_Done, o_Error}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", {28'd0, o_Mem_Req, o_Busy, o_Done, o_Error},
          32'd0);

    for (int i = 0; i < 7; i++) begin
      do_fetch(tbl[i], $sformatf("vec%0d", i));
    end

    // Ack pulses while idle must not start anything.
    pc0 = n_pc; dn0 = n_done; act = 0;
    for (int c = 0; c < 10; c++) begin
      i_Mem_Ack = c[0];
      i_Mem_Data = 8'hEE;
      @(negedge clk);
      if (o_Mem_Req || o_Busy) act++;
    end
    i_Mem_Ack = 1'b0;
    check("idle_ack_ignored", act, 0);
    check("idle_ack_no_write", n_pc - pc0, 0);
    check("idle_ack_no_done", n_done - dn0, 0);

    // Reset while waiting for the high byte.
    model_reg = 16'h0000;
    exp_q.push_back('{3'b101, 16'h7777});
    i_Mode = 2'b00;
    i_Start = 1'b1;
    @(negedge clk);
    i_Start = 1'b0;
    i_Mem_Ack = 1'b1;
    i_Mem_Data = 8'h77;
    @(negedge clk);
    i_Mem_Ack = 1'b0;
    @(negedge clk);
    check("hi_req_up", {30'd0, o_Mem_Req, o_Busy}, 32'd3);
    #2 rst = 1'b1;
    #1;
    check("rst_async_drop", {30'd0, o_Mem_Req, o_Busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pc0 = n_pc; dn0 = n_done;
    repeat (6) @(negedge clk);
    check("rst_no_hi_write", n_pc - pc0, 0);
    check("rst_no_done", n_done - dn0, 0);
    check("rst_reg_lo_only", {16'd0, model_reg}, 32'h0077);
    check("rst_q_empty", exp_q.size(), 0);
    do_fetch(tbl[2], "after_rst");

    // Memory never acks.
    pc0 = n_pc; dn0 = n_done;
    model_reg = 16'h0000;
    i_Mode = 2'b01;
    i_Start = 1'b1;
    i_Mem_Ack = 1'b0;
    reqs = 0; got = 0;
`ifdef FETCH_TIMEOUT_EN
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      i_Start = 1'b0;
      if (o_Mem_Req) reqs++;
      if (o_Error) got = 1;
    end
    check("to_error_seen", {31'd0, got}, 32'd1);
    check("to_req_cycles", reqs, 15);
    check("to_no_write", n_pc - pc0, 0);
    @(negedge clk);
    check("to_idle_after", {30'd0, o_Busy, o_Error}, 32'd0);
    check("to_no_done", n_done - dn0, 0);
`else
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      i_Start = 1'b0;
      if (o_Mem_Req) reqs++;
    end
    check("wait_req_held", reqs, 25);
    check("wait_no_error", n_errp, 0);
    exp_q.push_back('{3'b100, 16'h4242});
    i_Mem_Ack = 1'b1;
    i_Mem_Data = 8'h42;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      i_Mem_Ack = 1'b0;
      if (o_Done) got = 1;
    end
    check("wait_done_seen", {31'd0, got}, 32'd1);
    check("wait_reg", {16'd0, model_reg}, 32'h0042);
    check("wait_pc_pulses", n_pc - pc0, 1);
    @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
